// File: rtl/mealy_pkg.sv
// Shared tables for the 4-state Mealy sequence code.
// The encoder and mealy_decoder both use these functions so their tables cannot diverge.
//   mealy_next   : next tracker state from the current state and plain bit x
//   mealy_out    : encoded bit y that the encoder sends for (state, x)
//   mealy_decode : plain bit x recovered from (state, y)
package mealy_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } mealy_state_e;

   function automatic mealy_state_e mealy_next(input mealy_state_e state, input logic x);
      mealy_state_e nxt;
      nxt = S0;
      unique case (state)
         S0: nxt = x ? S0 : S1;
         S1: nxt = x ? S3 : S2;
         S2: nxt = x ? S1 : S0;
         S3: nxt = x ? S2 : S3;
         default: nxt = S0;
      endcase
      return nxt;
   endfunction

   // S1 and S2 invert the bit; S0 and S3 pass it through.
   function automatic logic mealy_out(input mealy_state_e state, input logic x);
      return x ^ (state[1] ^ state[0]);
   endfunction

   // The per-state map is an XOR, so decoding is the same operation.
   function automatic logic mealy_decode(input mealy_state_e state, input logic y);
      return y ^ (state[1] ^ state[0]);
   endfunction

endpackage

// File: rtl/mealy_decoder_if.sv
// Port bundle for mealy_decoder.
//   master : stream source / word consumer (drives y_in, y_valid, resync, word_ready)
//   slave  : the decoder (drives bit_out, bit_valid, word_out, word_valid, overrun, state_dbg)
interface mealy_decoder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             y_in;
   logic             y_valid;
   logic             resync;
   logic             bit_out;
   logic             bit_valid;
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             word_ready;
   logic             overrun;
   logic [1:0]       state_dbg;

   modport master (
      output y_in, y_valid, resync, word_ready,
      input  bit_out, bit_valid, word_out, word_valid, overrun, state_dbg
   );

   modport slave (
      input  y_in, y_valid, resync, word_ready,
      output bit_out, bit_valid, word_out, word_valid, overrun, state_dbg
   );
endinterface

// File: rtl/mealy_word_packer.sv
// Packs recovered bits LSB-first into WIDTH-bit words behind a valid/ready output.
//   clk, rst       : clock, asynchronous active-high reset
//   bit_i          : decoded bit, consumed when bit_valid_i
//   bit_valid_i    : bit_i is valid this cycle
//   clear_i        : drop the partial word (applied before a same-cycle bit)
//   word_ready_i   : consumer accepts word_o when word_valid_o && word_ready_i
//   word_o         : last completed word
//   word_valid_o   : word_o holds an unconsumed word
//   overrun_o      : sticky, a completed word was discarded
module mealy_word_packer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_i,
   input  logic             bit_valid_i,
   input  logic             clear_i,
   input  logic             word_ready_i,
   output logic [WIDTH-1:0] word_o,
   output logic             word_valid_o,
   output logic             overrun_o
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] shift_q, shift_d, shift_base, shift_new;
   logic [WIDTH-1:0] word_q, word_d;
   logic [CNT_W-1:0] count_q, count_d, count_base;
   logic             word_valid_q, word_valid_d;
   logic             overrun_q, overrun_d;

   always_comb begin
      shift_base   = clear_i ? '0 : shift_q;
      count_base   = clear_i ? '0 : count_q;
      // Bits above count are always zero, so OR-ing the new bit in is a write.
      shift_new    = shift_base | (WIDTH'(bit_i) << count_base);
      shift_d      = shift_base;
      count_d      = count_base;
      word_d       = word_q;
      word_valid_d = word_valid_q && !word_ready_i;
      overrun_d    = overrun_q;
      if (bit_valid_i) begin
         if (count_base == CNT_W'(WIDTH - 1)) begin
            shift_d = '0;
            count_d = '0;
            // Output slot is free if empty or being drained this very cycle.
            if (!word_valid_q || word_ready_i) begin
               word_d       = shift_new;
               word_valid_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end else begin
            shift_d = shift_new;
            count_d = count_base + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q      <= '0;
         count_q      <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         count_q      <= count_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = word_valid_q;
   assign overrun_o    = overrun_q;

endmodule

// File: rtl/mealy_decoder.sv
// Receive-side inverse of the 4-state Mealy sequence encoder.
// Tracks the encoder state from the y stream, recovers x, emits it as a registered
// bit pulse and packs it into words via mealy_word_packer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mealy_decoder_if.slave (y_in/y_valid/resync in, bit/word/overrun/state_dbg out)
module mealy_decoder
   import mealy_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   mealy_decoder_if.slave bus
);
   mealy_state_e     state_q, state_d, state_base;
   logic             bit_out_q, bit_out_d;
   logic             bit_valid_q, bit_valid_d;
   logic             x_dec;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             overrun;

   // Resync takes effect before a same-cycle bit, so that bit is decoded from S0.
   always_comb begin
      state_base  = bus.resync ? S0 : state_q;
      x_dec       = mealy_decode(state_base, bus.y_in);
      state_d     = state_base;
      bit_out_d   = bit_out_q;
      bit_valid_d = 1'b0;
      if (bus.y_valid) begin
         state_d     = mealy_next(state_base, x_dec);
         bit_out_d   = x_dec;
         bit_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
      end
   end

   mealy_word_packer #(
      .WIDTH (WIDTH)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .bit_i        (x_dec),
      .bit_valid_i  (bus.y_valid),
      .clear_i      (bus.resync),
      .word_ready_i (bus.word_ready),
      .word_o       (word),
      .word_valid_o (word_valid),
      .overrun_o    (overrun)
   );

   assign bus.bit_out    = bit_out_q;
   assign bus.bit_valid  = bit_valid_q;
   assign bus.word_out   = word;
   assign bus.word_valid = word_valid;
   assign bus.overrun    = overrun;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mealy_decoder.sv
module tb_mealy_decoder;

   logic clk;
   logic rst;

   mealy_decoder_if #(.WIDTH(8)) bus ();

   mealy_decoder #(
      .WIDTH (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [1:0] ms;  // encoder state model

   typedef struct packed {
      logic       y;
      logic       yv;
      logic       rdy;
      logic       eb;
      logic       ebv;
      logic [1:0] es;
      logic       ewv;
      logic [7:0] ew;
      logic       eov;
   } vec_t;

   vec_t tbl [18];

   function automatic logic [1:0] tb_next(input logic [1:0] s, input logic x);
      case (s)
         2'd0:    return x ? 2'd0 : 2'd1;
         2'd1:    return x ? 2'd3 : 2'd2;
         2'd2:    return x ? 2'd1 : 2'd0;
         default: return x ? 2'd2 : 2'd3;
      endcase
   endfunction

   function automatic logic tb_enc(input logic [1:0] s, input logic x);
      if (s == 2'd1 || s == 2'd2) return ~x;
      return x;
   endfunction

   function automatic vec_t mk(input logic y, input logic yv, input logic rdy, input logic eb,
                               input logic ebv, input logic [1:0] es, input logic ewv,
                               input logic [7:0] ew, input logic eov);
      vec_t v;
      v.y = y; v.yv = yv; v.rdy = rdy; v.eb = eb; v.ebv = ebv;
      v.es = es; v.ewv = ewv; v.ew = ew; v.eov = eov;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic y, input logic yv, input logic rs, input logic rdy);
      bus.y_in       = y;
      bus.y_valid    = yv;
      bus.resync     = rs;
      bus.word_ready = rdy;
      @(posedge clk);
      #1;
      bus.y_valid    = 1'b0;
      bus.resync     = 1'b0;
   endtask

   // Send one valid y, check decoded bit and state against the model.
   task automatic send_y(input logic y, input logic rs, input logic rdy, input string tag);
      logic [1:0] s0;
      logic       x;
      s0 = rs ? 2'd0 : ms;
      x  = y ^ (s0 == 2'd1 || s0 == 2'd2);
      ms = tb_next(s0, x);
      step(y, 1'b1, rs, rdy);
      chk({tag, " bit_out"}, 32'(bus.bit_out), 32'(x));
      chk({tag, " bit_valid"}, 32'(bus.bit_valid), 32'd1);
      chk({tag, " state"}, 32'(bus.state_dbg), 32'(ms));
   endtask

   task automatic send_x(input logic x, input logic rdy, input string tag);
      send_y(tb_enc(ms, x), 1'b0, rdy, tag);
   endtask

   task automatic do_reset();
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      ms = 2'd0;
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] mshift;
      logic [7:0] wexp;
      int         mcnt;
      logic       x, y, yv, done;

      clk            = 1'b0;
      rst            = 1'b0;
      bus.y_in       = 1'b0;
      bus.y_valid    = 1'b0;
      bus.resync     = 1'b0;
      bus.word_ready = 1'b0;
      ms             = 2'd0;
      pat            = 8'b1100_1100;

      // Reset state, before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("reset bit_out", 32'(bus.bit_out), 32'd0);
      chk("reset bit_valid", 32'(bus.bit_valid), 32'd0);
      chk("reset word_out", 32'(bus.word_out), 32'd0);
      chk("reset word_valid", 32'(bus.word_valid), 32'd0);
      chk("reset overrun", 32'(bus.overrun), 32'd0);
      chk("reset state", 32'(bus.state_dbg), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Sequence walk y=0,0,1,1 then word packing
      tbl[0]  = mk(0, 1, 0, 0, 1, 2'd1, 0, 8'h00, 0);
      tbl[1]  = mk(0, 1, 0, 1, 1, 2'd3, 0, 8'h00, 0);
      tbl[2]  = mk(1, 1, 0, 1, 1, 2'd2, 0, 8'h00, 0);
      tbl[3]  = mk(1, 1, 0, 0, 1, 2'd0, 0, 8'h00, 0);
      for (int i = 4; i < 7; i++) tbl[i] = mk(1, 1, 0, 1, 1, 2'd0, 0, 8'h00, 0);
      tbl[7]  = mk(1, 1, 0, 1, 1, 2'd0, 1, 8'hF6, 0);
      tbl[8]  = mk(0, 0, 1, 1, 0, 2'd0, 0, 8'hF6, 0);
      for (int i = 9; i < 16; i++) tbl[i] = mk(1, 1, 0, 1, 1, 2'd0, 0, 8'hF6, 0);
      tbl[16] = mk(1, 1, 0, 1, 1, 2'd0, 1, 8'hFF, 0);
      tbl[17] = mk(0, 0, 0, 1, 0, 2'd0, 1, 8'hFF, 0);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].y, tbl[i].yv, 1'b0, tbl[i].rdy);
         chk($sformatf("vec%0d bit_out", i), 32'(bus.bit_out), 32'(tbl[i].eb));
         chk($sformatf("vec%0d bit_valid", i), 32'(bus.bit_valid), 32'(tbl[i].ebv));
         chk($sformatf("vec%0d state", i), 32'(bus.state_dbg), 32'(tbl[i].es));
         chk($sformatf("vec%0d word_valid", i), 32'(bus.word_valid), 32'(tbl[i].ewv));
         chk($sformatf("vec%0d word_out", i), 32'(bus.word_out), 32'(tbl[i].ew));
         chk($sformatf("vec%0d overrun", i), 32'(bus.overrun), 32'(tbl[i].eov));
      end
      ms = 2'd0;

      // Overrun: consumer stalled across two more full words
      for (int k = 0; k < 16; k++) begin
         send_y(pat[k % 8], 1'b0, 1'b0, $sformatf("ovr%0d", k));
         chk($sformatf("ovr%0d overrun", k), 32'(bus.overrun), 32'(k >= 7));
         chk($sformatf("ovr%0d word_out", k), 32'(bus.word_out), 32'hFF);
         chk($sformatf("ovr%0d word_valid", k), 32'(bus.word_valid), 32'd1);
      end

      // Load of a new word in the same cycle the held word is accepted
      do_reset();
      chk("rst2 overrun", 32'(bus.overrun), 32'd0);
      for (int k = 0; k < 8; k++) send_y(1'b1, 1'b0, 1'b0, "w1");
      chk("w1 word_valid", 32'(bus.word_valid), 32'd1);
      chk("w1 word_out", 32'(bus.word_out), 32'hFF);
      for (int k = 0; k < 7; k++) send_y(pat[k], 1'b0, 1'b0, "w2");
      chk("w2 held word", 32'(bus.word_out), 32'hFF);
      send_y(pat[7], 1'b0, 1'b1, "w2 last");
      chk("swap word_valid", 32'(bus.word_valid), 32'd1);
      chk("swap word_out", 32'(bus.word_out), 32'h66);
      chk("swap overrun", 32'(bus.overrun), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("drain word_valid", 32'(bus.word_valid), 32'd0);
      chk("drain word_out", 32'(bus.word_out), 32'h66);

      // Resync with a simultaneous valid bit
      for (int k = 0; k < 3; k++) send_y(1'b1, 1'b0, 1'b0, "pre");
      send_y(1'b0, 1'b1, 1'b0, "resync");
      chk("resync state S1", 32'(bus.state_dbg), 32'd1);
      chk("resync bit 0", 32'(bus.bit_out), 32'd0);
      for (int k = 0; k < 6; k++) begin
         send_x(1'b1, 1'b0, $sformatf("post%0d", k));
         chk($sformatf("post%0d word_valid", k), 32'(bus.word_valid), 32'd0);
      end
      send_x(1'b1, 1'b0, "post6");
      chk("resync word_valid", 32'(bus.word_valid), 32'd1);
      chk("resync word_out", 32'(bus.word_out), 32'hFE);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      ms = 2'd0;
      chk("resync alone state", 32'(bus.state_dbg), 32'd0);
      chk("resync alone word_out", 32'(bus.word_out), 32'hFE);
      chk("resync alone word_valid", 32'(bus.word_valid), 32'd1);

      // Asynchronous reset mid-word with a word held
      for (int k = 0; k < 4; k++) send_y(1'b0, 1'b0, 1'b0, "mid");
      send_y(1'b1, 1'b0, 1'b0, "mid4");
      chk("mid word_valid", 32'(bus.word_valid), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("async bit_out", 32'(bus.bit_out), 32'd0);
      chk("async bit_valid", 32'(bus.bit_valid), 32'd0);
      chk("async word_out", 32'(bus.word_out), 32'd0);
      chk("async word_valid", 32'(bus.word_valid), 32'd0);
      chk("async overrun", 32'(bus.overrun), 32'd0);
      chk("async state", 32'(bus.state_dbg), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      ms = 2'd0;

      // Random x through the encoder model, always-ready consumer
      mcnt   = 0;
      mshift = 8'h00;
      wexp   = 8'h00;
      for (int i = 0; i < 400; i++) begin
         yv   = ($urandom_range(0, 3) != 0);
         x    = 1'($urandom_range(0, 1));
         y    = tb_enc(ms, x);
         done = 1'b0;
         if (yv) begin
            mshift[mcnt] = x;
            ms           = tb_next(ms, x);
            mcnt++;
            if (mcnt == 8) begin
               wexp   = mshift;
               done   = 1'b1;
               mcnt   = 0;
               mshift = 8'h00;
            end
         end
         step(y, yv, 1'b0, 1'b1);
         chk($sformatf("rnd%0d bit_valid", i), 32'(bus.bit_valid), 32'(yv));
         if (yv) chk($sformatf("rnd%0d bit_out", i), 32'(bus.bit_out), 32'(x));
         chk($sformatf("rnd%0d state", i), 32'(bus.state_dbg), 32'(ms));
         chk($sformatf("rnd%0d word_valid", i), 32'(bus.word_valid), 32'(done));
         if (done) chk($sformatf("rnd%0d word_out", i), 32'(bus.word_out), 32'(wexp));
      end
      chk("rnd overrun", 32'(bus.overrun), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
